// File: rtl/mdu_controller.sv
// Sequencing controller for the RV32M multiply/divide datapath: decodes M ops in EX,
// pulses the datapath start, stalls the pipe for the op latency and strobes writeback.
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif

module mdu_controller #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 33,
  parameter int unsigned CNT_W      = 6,
  parameter bit          ENABLE_DIV = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ex_valid,
  input  logic [6:0]              opcode,
  input  logic [2:0]              funct3,
  input  logic [6:0]              funct7,
  input  logic [`RFIDX_WIDTH-1:0] rd,
  input  logic                    rs2_zero,
  input  logic                    flush,
  output logic                    is_mdu,
  output logic                    stall,
  output logic                    mdu_start,
  output logic                    mdu_kill,
  output logic [2:0]              mdu_op,
  output logic                    mdu_done,
  output logic                    mdu_regwrite,
  output logic [`RFIDX_WIDTH-1:0] mdu_rd,
  output logic                    mdu_divzero,
  output logic [1:0]              dbg_state_o
);

  // Handshake: the controller takes the EX instruction in the cycle where it is IDLE,
  // ex_valid & is_mdu are high and flush is low; it then holds stall high until the
  // result cycle (DONE), where stall drops so the instruction leaves EX with its result.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2:0]              op_q, op_d;
  logic [`RFIDX_WIDTH-1:0] rd_q, rd_d;
  logic                    divzero_q, divzero_d;
  logic                    start_q, start_d;

  logic dec_m;
  logic accept;
  logic in_done;

  assign dec_m  = (opcode == 7'b0110011) && (funct7 == 7'b0000001) &&
                  (ENABLE_DIV || !funct3[2]);
  assign accept = !reset && (state_q == S_IDLE) && ex_valid && dec_m && !flush;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = rd_q;
    divzero_d = divzero_q;
    start_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d      = funct3;
          rd_d      = rd;
          divzero_d = funct3[2] && rs2_zero;
          // Divide by zero skips the datapath: result is a fixed ISA value.
          if (funct3[2] && rs2_zero) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            cnt_d   = funct3[2] ? DIV_LOAD : MUL_LOAD;
            start_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d   = S_IDLE;
        divzero_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      divzero_q <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      divzero_q <= divzero_d;
      start_q   <= start_d;
    end
  end

  // Outputs are forced low while reset is held so nothing leaks out mid-reset.
  assign in_done      = !reset && (state_q == S_DONE);
  assign is_mdu       = !reset && dec_m;
  assign stall        = accept || (!reset && (state_q == S_RUN));
  assign mdu_start    = !reset && start_q && !flush;
  assign mdu_kill     = !reset && flush && (state_q != S_IDLE);
  assign mdu_done     = in_done && !flush;
  assign mdu_regwrite = mdu_done && (rd_q != '0);
  assign mdu_divzero  = in_done && divzero_q;
  assign mdu_op       = reset ? 3'b000 : op_q;
  assign mdu_rd       = reset ? '0 : rd_q;
  assign dbg_state_o  = state_q;

endmodule

// File: doc/mdu_controller.md
# mdu_controller

Sequencing controller for the RV32M multiply/divide unit, in the EX stage next to the main decoder/controller. It decodes M-extension instructions (opcode 0110011, funct7 0000001) and issues a start pulse to the iterative multiply/divide datapath. It stalls the pipeline for a parametrised number of cycles and produces the writeback strobe and destination register. Divide-by-zero completes on a one-cycle fast path; a flush aborts an operation at any point.

## Interface
- MUL_CYCLES, 4: datapath cycles for MUL/MULH/MULHSU/MULHU; range 1..2^CNT_W
- DIV_CYCLES, 33: datapath cycles for DIV/DIVU/REM/REMU; range 1..2^CNT_W
- CNT_W, 6: cycle-counter width
- ENABLE_DIV, 1: when 0, funct3[2]=1 ops are not decoded as M ops; is_mdu=0 for them
- clk  in  1  rising-edge clock (one clock)
- reset  in  1  synchronous, active-high
- ex_valid  in  1  valid instruction in EX
- opcode  in  7  instruction opcode
- funct3  in  3  instruction funct3
- funct7  in  7  instruction funct7
- rd  in  `RFIDX_WIDTH  destination register index
- rs2_zero  in  1  rs2 operand equals 0, from forwarding
- flush  in  1  kill EX-stage work (branch/jump redirect)
- is_mdu  out  1  combinational decode: the EX instruction is an enabled M op
- stall  out  1  hold IF/ID/EX
- mdu_start  out  1  one-cycle start pulse to the datapath
- mdu_kill  out  1  one-cycle abort pulse to the datapath
- mdu_op  out  3  latched funct3, selects the datapath operation
- mdu_done  out  1  result valid this cycle
- mdu_regwrite  out  1  write the result to the register file
- mdu_rd  out  `RFIDX_WIDTH  latched destination
- mdu_divzero  out  1  select the ISA divide-by-zero result (DIV/DIVU = all ones, REM/REMU = dividend)

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE, cnt=0, mdu_op=0, mdu_rd=0, divzero flag=0. Every output is 0 during and after reset until the next accept.
- accept = IDLE & ex_valid & is_mdu & ~flush.
- On accept:
  - Latch mdu_op=funct3 and mdu_rd=rd.
  - div = funct3[2].
  - If div & rs2_zero: go to DONE, set the divzero flag, do not start the datapath.
  - Otherwise: go to RUN, load cnt = (div ? DIV_CYCLES : MUL_CYCLES) - 1, and register mdu_start=1 for the next cycle only.
- RUN:
  - If cnt==0, go to DONE.
  - Otherwise cnt decrements.
  - Counting never wraps; cnt==0 is terminal.
- DONE:
  - mdu_done = ~flush.
  - mdu_regwrite = ~flush & (mdu_rd != 0).
  - mdu_divzero = divzero flag.
  - Next state is always IDLE; the divzero flag clears.
- Decode of a non-M instruction, or ex_valid=0, in IDLE: no state change, stall=0.
- stall = accept | (state==RUN). stall is 0 in DONE, so the instruction leaves EX with its result.
- Flush in RUN or DONE:
  - Next state IDLE.
  - mdu_kill=1 in that same cycle (combinational).
  - Any mdu_start registered for that cycle is suppressed.
  - mdu_done and mdu_regwrite are 0.
- Flush in IDLE: no accept; flush has priority over ex_valid.
- rd=x0: the operation runs to completion; mdu_regwrite=0, mdu_done=1.
- Reset asserted in any state: IDLE next cycle, no done, no kill.

## Timing
- Accept in cycle T:
  - stall=1 in T (combinational from accept).
  - State RUN from T+1; mdu_start=1 in T+1 only.
  - stall=1 for T..T+N, where N = MUL_CYCLES or DIV_CYCLES.
  - DONE in T+N+1 with mdu_done=1.
  - IDLE in T+N+2; a back-to-back M op can be accepted there.
- Total latency from accept to done is N+1 cycles, i.e. N+1 stall cycles.
- Divide-by-zero: stall=1 in T only; DONE in T+1 with mdu_divzero=1; mdu_start never asserted.
- N=1: RUN lasts one cycle (T+1); DONE in T+2.
- mdu_op and mdu_rd stay stable from T+1 through DONE.

## Test plan
- MUL x5,x6,x7 with MUL_CYCLES=4, accepted in cycle 10 -> mdu_start in 11; stall in 10..14; mdu_done=1, mdu_regwrite=1, mdu_rd=5, mdu_op=000 in 15; IDLE in 16.
- DIVU x3 with rs2_zero=1, accepted in cycle 10 -> stall only in 10; no mdu_start; cycle 11: mdu_done=1, mdu_divzero=1, mdu_op=101.
- DIV with DIV_CYCLES=33, flush in the 20th RUN cycle -> mdu_kill=1 that cycle; mdu_done never asserted; stall=0 the next cycle; a new MUL is accepted one cycle later.
- REM to x0 -> mdu_done=1 after N+1 cycles with mdu_regwrite=0. Separately, reset mid-RUN -> all outputs 0 the next cycle.
- ENABLE_DIV=0: DIV presented -> is_mdu=0, stall=0. ADD (funct7=0000000) -> is_mdu=0.
- Two MULs back-to-back (second held in EX by stall) -> second accepted exactly in the cycle after the first's DONE; two mdu_done pulses separated by MUL_CYCLES+2 cycles.
